knn_seq: RTL and testbench

- Sequencer and initiator for the multi-solver knn core.
- Accepts one upstream valid/ready word stream: test points first, then training points.
  - Loads one test point into each solver slot.
  - Streams the training points into all solvers and pulses the core's done input.
- Then sweeps solver/rank selects and returns every neighbour label as a valid/ready result stream.
- Sits between the system data interface and the knn core; it is the side that drives the core.

---
 rtl/knn_seq.sv | 221 ++++++++++++++++++++++
 tb/tb_knn_seq.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/knn_seq.sv
// rtl/knn_seq.sv - sequencer that loads, trains and reads out the multi-solver knn core
module knn_seq #(
  parameter int DATA_W    = 32,
  parameter int N_SOLVERS = 4,
  parameter int HW_K      = 10,
  parameter int SOLVER_W  = 16,
  parameter int DRAIN     = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [SOLVER_W-1:0]   n_test,
  input  logic [15:0]           n_train,
  output logic                  busy,
  output logic                  run_done,
  input  logic [DATA_W-1:0]     in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_W-1:0]     core_data_1,
  output logic [DATA_W-1:0]     core_data_2,
  output logic [SOLVER_W-1:0]   core_solver_sel,
  output logic                  core_valid,
  output logic                  core_done,
  output logic [15:0]           core_sel,
  input  logic [DATA_W/4-1:0]   core_data_out,
  output logic [DATA_W/4-1:0]   res_data,
  output logic [SOLVER_W-1:0]   res_solver,
  output logic [15:0]           res_rank,
  output logic                  res_valid,
  input  logic                  res_ready
);

  localparam int LBL_W = DATA_W / 4;
  // Out-of-range slot index: the core ignores loads while the select rests here.
  localparam logic [SOLVER_W-1:0] PARK = SOLVER_W'(N_SOLVERS);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_STREAM, S_FLUSH, S_DRAIN, S_SEL, S_CAP, S_OUT
  } state_t;

  state_t              state_q, state_d;
  logic [SOLVER_W-1:0] n_test_q, n_test_d;
  logic [15:0]         n_train_q, n_train_d;
  logic [15:0]         cnt_q, cnt_d;
  logic [SOLVER_W-1:0] s_q, s_d;
  logic [15:0]         k_q, k_d;
  logic [DATA_W-1:0]   core_data_1_q, core_data_1_d;
  logic [DATA_W-1:0]   core_data_2_q, core_data_2_d;
  logic [SOLVER_W-1:0] core_solver_sel_q, core_solver_sel_d;
  logic                core_valid_q, core_valid_d;
  logic                core_done_q, core_done_d;
  logic [15:0]         core_sel_q, core_sel_d;
  logic [LBL_W-1:0]    res_data_q, res_data_d;
  logic [SOLVER_W-1:0] res_solver_q, res_solver_d;
  logic [15:0]         res_rank_q, res_rank_d;
  logic                res_valid_q, res_valid_d;
  logic                run_done_q, run_done_d;
  logic                in_fire;

  assign busy            = (state_q != S_IDLE);
  assign in_ready        = (state_q == S_LOAD) || (state_q == S_STREAM);
  assign in_fire         = in_valid && in_ready;
  assign run_done        = run_done_q;
  assign core_data_1     = core_data_1_q;
  assign core_data_2     = core_data_2_q;
  assign core_solver_sel = core_solver_sel_q;
  assign core_valid      = core_valid_q;
  assign core_done       = core_done_q;
  assign core_sel        = core_sel_q;
  assign res_data        = res_data_q;
  assign res_solver      = res_solver_q;
  assign res_rank        = res_rank_q;
  assign res_valid       = res_valid_q;

  // State and output registers; reset abandons any run in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q           <= S_IDLE;
      n_test_q          <= '0;
      n_train_q         <= '0;
      cnt_q             <= '0;
      s_q               <= '0;
      k_q               <= '0;
      core_data_1_q     <= '0;
      core_data_2_q     <= '0;
      core_solver_sel_q <= PARK;
      core_valid_q      <= 1'b0;
      core_done_q       <= 1'b0;
      core_sel_q        <= '0;
      res_data_q        <= '0;
      res_solver_q      <= '0;
      res_rank_q        <= '0;
      res_valid_q       <= 1'b0;
      run_done_q        <= 1'b0;
    end else begin
      state_q           <= state_d;
      n_test_q          <= n_test_d;
      n_train_q         <= n_train_d;
      cnt_q             <= cnt_d;
      s_q               <= s_d;
      k_q               <= k_d;
      core_data_1_q     <= core_data_1_d;
      core_data_2_q     <= core_data_2_d;
      core_solver_sel_q <= core_solver_sel_d;
      core_valid_q      <= core_valid_d;
      core_done_q       <= core_done_d;
      core_sel_q        <= core_sel_d;
      res_data_q        <= res_data_d;
      res_solver_q      <= res_solver_d;
      res_rank_q        <= res_rank_d;
      res_valid_q       <= res_valid_d;
      run_done_q        <= run_done_d;
    end
  end

  // Next-state and next-output decode; strobes default low, data holds.
  always_comb begin
    state_d           = state_q;
    n_test_d          = n_test_q;
    n_train_d         = n_train_q;
    cnt_d             = cnt_q;
    s_d               = s_q;
    k_d               = k_q;
    core_data_1_d     = core_data_1_q;
    core_data_2_d     = core_data_2_q;
    core_solver_sel_d = core_solver_sel_q;
    core_valid_d      = 1'b0;
    core_done_d       = 1'b0;
    core_sel_d        = core_sel_q;
    res_data_d        = res_data_q;
    res_solver_d      = res_solver_q;
    res_rank_d        = res_rank_q;
    res_valid_d       = res_valid_q;
    run_done_d        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && (n_test != '0) && (n_test <= PARK)) begin
          n_test_d  = n_test;
          n_train_d = n_train;
          cnt_d     = '0;
          state_d   = S_LOAD;
        end
      end
      S_LOAD: begin
        core_solver_sel_d = PARK;
        if (in_fire) begin
          core_data_1_d     = in_data;
          core_solver_sel_d = SOLVER_W'(cnt_q);
          if (cnt_q == 16'(n_test_q) - 16'd1) begin
            cnt_d   = '0;
            state_d = (n_train_q == 16'd0) ? S_FLUSH : S_STREAM;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      S_STREAM: begin
        core_solver_sel_d = PARK;
        if (in_fire) begin
          core_valid_d  = 1'b1;
          core_data_2_d = in_data;
          if (cnt_q == n_train_q - 16'd1) begin
            cnt_d   = '0;
            state_d = S_FLUSH;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      S_FLUSH: begin
        // Issued here so the pulse lands after the last training strobe.
        core_solver_sel_d = PARK;
        core_done_d       = 1'b1;
        cnt_d             = '0;
        state_d           = S_DRAIN;
      end
      S_DRAIN: begin
        if (cnt_q == 16'(DRAIN - 1)) begin
          cnt_d   = '0;
          s_d     = '0;
          k_d     = '0;
          state_d = S_SEL;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_SEL: begin
        core_solver_sel_d = s_q;
        core_sel_d        = k_q;
        state_d           = S_CAP;
      end
      S_CAP: begin
        res_data_d   = core_data_out;
        res_solver_d = s_q;
        res_rank_d   = k_q;
        res_valid_d  = 1'b1;
        state_d      = S_OUT;
      end
      S_OUT: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          if (k_q != 16'(HW_K - 1)) begin
            k_d     = k_q + 16'd1;
            state_d = S_SEL;
          end else if (s_q != n_test_q - SOLVER_W'(1)) begin
            s_d     = s_q + SOLVER_W'(1);
            k_d     = '0;
            state_d = S_SEL;
          end else begin
            run_done_d        = 1'b1;
            core_solver_sel_d = PARK;
            core_sel_d        = '0;
            state_d           = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_knn_seq.sv
// tb/tb_knn_seq.sv - randomized self-checking bench for knn_seq against a queue-based model
module tb_knn_seq;

  localparam int NS = 4;
  localparam int K  = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] n_test;
  logic [15:0] n_train;
  logic        busy, run_done;
  logic [31:0] in_data;
  logic        in_valid, in_ready;
  logic [31:0] core_data_1, core_data_2;
  logic [15:0] core_solver_sel, core_sel;
  logic        core_valid, core_done;
  logic [7:0]  core_data_out;
  logic [7:0]  res_data;
  logic [15:0] res_solver, res_rank;
  logic        res_valid, res_ready;
  logic [7:0]  salt;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] words[$];
  logic [47:0] loads[$];
  logic [31:0] train[$];
  logic [39:0] results[$];
  int          done_cnt, rd_cnt;
  bit          cons_done;

  always #5 clk = ~clk;

  knn_seq dut (
    .clk(clk), .rst(rst), .start(start), .n_test(n_test), .n_train(n_train),
    .busy(busy), .run_done(run_done), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .core_data_1(core_data_1), .core_data_2(core_data_2),
    .core_solver_sel(core_solver_sel), .core_valid(core_valid), .core_done(core_done),
    .core_sel(core_sel), .core_data_out(core_data_out), .res_data(res_data),
    .res_solver(res_solver), .res_rank(res_rank), .res_valid(res_valid),
    .res_ready(res_ready)
  );

  // Stand-in for the core: each (solver, rank) holds a distinct label.
  function automatic logic [7:0] lbl(input logic [15:0] s, input logic [15:0] k,
                                     input logic [7:0] sl);
    logic [31:0] t;
    t = 32'(s) * 32'd37 + 32'(k) * 32'd11;
    return t[7:0] ^ sl;
  endfunction

  assign core_data_out = lbl(core_solver_sel, core_sel, salt);

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_run_done"}, run_done, 0);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_core_data_1"}, core_data_1, 0);
    check({tag, "_core_data_2"}, core_data_2, 0);
    check({tag, "_core_solver_sel"}, core_solver_sel, NS);
    check({tag, "_core_valid"}, core_valid, 0);
    check({tag, "_core_done"}, core_done, 0);
    check({tag, "_core_sel"}, core_sel, 0);
    check({tag, "_res_data"}, res_data, 0);
    check({tag, "_res_solver"}, res_solver, 0);
    check({tag, "_res_rank"}, res_rank, 0);
    check({tag, "_res_valid"}, res_valid, 0);
  endtask

  task automatic fill_random(input int total);
    words.delete();
    for (int i = 0; i < total; i++) words.push_back($urandom);
  endtask

  // vmode: 0 always valid, 1 toggling, 2 random. stall<0 means random stall per result.
  task automatic run(input int nt, input int ntr, input int vmode, input int stall,
                     input bit mid_start);
    int total;
    total = nt + ntr;
    loads.delete(); train.delete(); results.delete();
    done_cnt = 0; rd_cnt = 0; cons_done = 0;
    salt = 8'($urandom);
    @(posedge clk); #1;
    n_test = 16'(nt); n_train = 16'(ntr); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", busy, 1);
    fork
      begin : feeder
        int idx, cyc;
        bit hs, pulsed;
        idx = 0; cyc = 0; pulsed = 0;
        if (total > 0) begin
          in_data = words[0];
          in_valid = (vmode == 1) ? 1'b1 : (vmode == 2) ? 1'($urandom) : 1'b1;
          while (idx < total && cyc < 4000) begin
            @(negedge clk);
            hs = in_valid && in_ready;
            @(posedge clk); #1;
            cyc++;
            start = 1'b0;
            if (hs) idx++;
            if (mid_start && !pulsed && idx > nt && idx < total) begin
              start = 1'b1; n_test = 16'd3; pulsed = 1;
            end
            if (idx < total) begin
              in_data = words[idx];
              in_valid = (vmode == 1) ? 1'(cyc % 2 == 0) :
                         (vmode == 2) ? 1'($urandom) : 1'b1;
            end
          end
          if (idx < total) check("feeder_timeout", idx, total);
        end
        start = 1'b0;
        // Offer a stray word for the rest of the run; it must never be taken.
        in_data = 32'hDEADBEEF;
        in_valid = 1'b1;
      end
      begin : consumer
        int got, cyc, scnt, slim;
        got = 0; cyc = 0; scnt = 0;
        slim = (stall < 0) ? $urandom_range(0, 3) : stall;
        res_ready = 1'b0;
        while (got < nt * K && cyc < 6000) begin
          @(negedge clk);
          cyc++;
          if (res_valid && res_ready) begin
            results.push_back({res_data, res_solver, res_rank});
            got++;
          end
          @(posedge clk); #1;
          if (res_valid && scnt >= slim) begin
            res_ready = 1'b1;
          end else begin
            res_ready = 1'b0;
            if (res_valid) scnt++;
            else begin
              scnt = 0;
              slim = (stall < 0) ? $urandom_range(0, 3) : stall;
            end
          end
        end
        if (got < nt * K) check("consumer_timeout", got, nt * K);
        cons_done = 1;
      end
      begin : monitor
        int extra, cyc;
        bit done_seen, stalled;
        logic [39:0] held;
        extra = 0; cyc = 0; done_seen = 0; stalled = 0; held = '0;
        while (extra < 3 && cyc < 12000) begin
          @(negedge clk);
          cyc++;
          if (cons_done) extra++;
          if (!done_seen && core_solver_sel != 16'(NS))
            loads.push_back({core_solver_sel, core_data_1});
          if (core_valid) train.push_back(core_data_2);
          if (core_valid && core_done) check("valid_with_done", 1, 0);
          if (done_seen && in_ready) check("in_ready_after_done", in_ready, 0);
          if (core_done) begin
            done_cnt++;
            done_seen = 1;
          end
          if (run_done) rd_cnt++;
          if (stalled) begin
            check("res_valid_held", res_valid, 1);
            check("res_fields_held", {res_data, res_solver, res_rank}, held);
          end
          stalled = res_valid && !res_ready;
          held = {res_data, res_solver, res_rank};
        end
      end
    join
    in_valid = 1'b0;
    res_ready = 1'b0;
    check("load_count", loads.size(), nt);
    for (int i = 0; i < nt && i < loads.size(); i++)
      check($sformatf("load_%0d", i), loads[i], {16'(i), words[i]});
    check("train_count", train.size(), ntr);
    for (int i = 0; i < ntr && i < train.size(); i++)
      check($sformatf("train_%0d", i), train[i], words[nt + i]);
    check("core_done_pulses", done_cnt, 1);
    check("run_done_pulses", rd_cnt, 1);
    check("result_count", results.size(), nt * K);
    for (int s = 0; s < nt; s++)
      for (int k = 0; k < K; k++)
        if (s * K + k < results.size())
          check($sformatf("result_s%0d_k%0d", s, k), results[s * K + k],
                {lbl(16'(s), 16'(k), salt), 16'(s), 16'(k)});
    check("busy_after_run", busy, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; n_test = '0; n_train = '0;
    in_data = '0; in_valid = 1'b0; res_ready = 1'b0; salt = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_idle_outputs("reset");

    // Illegal slot counts are ignored.
    n_test = 16'd0; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check("start_nt0_busy", busy, 0);
    n_test = 16'd5; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check("start_nt5_busy", busy, 0);
    check("start_nt5_in_ready", in_ready, 0);

    words = '{32'h00010001, 32'h00050005, 32'h00020002, 32'h00090009};
    run(1, 3, 0, 0, 0);

    fill_random(4 + 7);
    run(4, 7, 0, 0, 0);

    fill_random(2 + 8);
    run(2, 8, 1, 5, 1);

    fill_random(3);
    run(3, 0, 2, 1, 0);

    // Reset in the middle of training abandons the run.
    @(posedge clk); #1;
    n_test = 16'd2; n_train = 16'd20; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    in_valid = 1'b1; in_data = 32'h12345678;
    repeat (5) @(posedge clk);
    #1 check("pre_reset_in_stream", in_ready, 1);
    rst = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    check_idle_outputs("mid_reset");
    repeat (3) @(posedge clk);
    #1 check("mid_reset_no_run_done", run_done, 0);

    fill_random(2 + 5);
    run(2, 5, 0, 0, 0);

    for (int r = 0; r < 5; r++) begin
      int nt, ntr;
      nt = $urandom_range(1, NS);
      ntr = $urandom_range(0, 12);
      fill_random(nt + ntr);
      run(nt, ntr, $urandom_range(0, 2), -1, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
